// File: rtl/conv5x5_feeder.sv
// Sequencer for the 5x5 power-of-two systolic kernel: loads weight columns, streams
// byte-serial pixel columns, drives the kernel ctrl word and tags full-window results.
module conv5x5_feeder #(
  parameter int unsigned COLS    = 32,
  parameter int unsigned OUT_LAT = 11,
  parameter int unsigned RES_DLY = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        reuse_w,
  input  logic        w_valid,
  output logic        w_ready,
  input  logic [19:0] w_data,
  input  logic        px_valid,
  output logic        px_ready,
  input  logic [39:0] px_data,
  output logic [7:0]  in1,
  output logic [7:0]  in2,
  output logic [7:0]  in3,
  output logic [7:0]  in4,
  output logic [7:0]  in5,
  output logic [3:0]  ctrl,
  output logic        res_valid,
  output logic        res_msb,
  output logic        line_done,
  output logic        underrun
);

  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned DW = $clog2(OUT_LAT + 2);
  localparam int unsigned MW = RES_DLY + 1;
  localparam int unsigned TW = OUT_LAT + 1;

  typedef enum logic [2:0] {IDLE, WLOAD, DATA_L, DATA_M, DRAIN} state_t;

  state_t         state;
  logic [2:0]     beat;
  logic           half;
  logic [CW-1:0]  col;
  logic [DW-1:0]  dcnt;
  logic [2:0]     ctrl_lo;
  logic [MW-1:0]  msb_pipe;
  logic [TW-1:0]  tag;

  // Carry select is the MSB-phase flag seen through a RES_DLY-stage delay line
  assign ctrl = {msb_pipe[RES_DLY], ctrl_lo};

  // State register and registered outputs; each edge registers the slot decided by state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat      <= '0;
      half      <= 1'b0;
      col       <= '0;
      dcnt      <= '0;
      ctrl_lo   <= 3'b100;
      msb_pipe  <= '0;
      tag       <= '0;
      in1       <= '0;
      in2       <= '0;
      in3       <= '0;
      in4       <= '0;
      in5       <= '0;
      w_ready   <= 1'b0;
      px_ready  <= 1'b0;
      res_valid <= 1'b0;
      res_msb   <= 1'b0;
      line_done <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      line_done <= 1'b0;
      msb_pipe  <= msb_pipe << 1;
      tag       <= tag << 1;
      res_valid <= tag[OUT_LAT-1] | tag[OUT_LAT];
      res_msb   <= tag[OUT_LAT];
      case (state)
        IDLE: begin
          ctrl_lo <= 3'b100;
          in1 <= '0; in2 <= '0; in3 <= '0; in4 <= '0; in5 <= '0;
          // A start coinciding with line_done is dropped
          if (start && !line_done) begin
            underrun <= 1'b0;
            beat     <= '0;
            half     <= 1'b0;
            col      <= '0;
            dcnt     <= '0;
            if (reuse_w) begin
              px_ready <= 1'b1;
              state    <= DATA_L;
            end else begin
              w_ready <= 1'b1;
              state   <= WLOAD;
            end
          end
        end
        WLOAD: begin
          if (!half) begin
            if (w_valid) begin
              in1     <= {4'b0, w_data[3:0]};
              in2     <= {4'b0, w_data[7:4]};
              in3     <= {4'b0, w_data[11:8]};
              in4     <= {4'b0, w_data[15:12]};
              in5     <= {4'b0, w_data[19:16]};
              w_ready <= 1'b0;
              if (beat == 3'd4) begin
                ctrl_lo  <= 3'b001;
                px_ready <= 1'b1;
                state    <= DATA_L;
              end else begin
                ctrl_lo <= 3'b000;
                half    <= 1'b1;
              end
            end else begin
              ctrl_lo <= 3'b100;
            end
          end else begin
            ctrl_lo <= 3'b000;
            half    <= 1'b0;
            beat    <= beat + 3'd1;
            w_ready <= 1'b1;
          end
        end
        DATA_L: begin
          ctrl_lo  <= 3'b010;
          px_ready <= 1'b0;
          // The array cannot stall mid-line, so a missing column becomes zeros
          if (px_valid) begin
            in1 <= px_data[7:0];
            in2 <= px_data[15:8];
            in3 <= px_data[23:16];
            in4 <= px_data[31:24];
            in5 <= px_data[39:32];
          end else begin
            in1 <= '0; in2 <= '0; in3 <= '0; in4 <= '0; in5 <= '0;
            underrun <= 1'b1;
          end
          if (col >= CW'(4)) tag <= (tag << 1) | TW'(1);
          state <= DATA_M;
        end
        DATA_M: begin
          ctrl_lo  <= 3'b100;
          msb_pipe <= (msb_pipe << 1) | MW'(1);
          if (col == CW'(COLS - 1)) begin
            dcnt  <= '0;
            state <= DRAIN;
          end else begin
            col      <= col + CW'(1);
            px_ready <= 1'b1;
            state    <= DATA_L;
          end
        end
        DRAIN: begin
          in1 <= '0; in2 <= '0; in3 <= '0; in4 <= '0; in5 <= '0;
          if (!dcnt[0]) begin
            ctrl_lo <= 3'b010;
          end else begin
            ctrl_lo  <= 3'b100;
            msb_pipe <= (msb_pipe << 1) | MW'(1);
          end
          if (dcnt == DW'(OUT_LAT + 1)) begin
            line_done <= 1'b1;
            state     <= IDLE;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv5x5_feeder.sv
// Directed bench for conv5x5_feeder (COLS=8, OUT_LAT=11): per-cycle check of ctrl, in*,
// handshakes and result tags against a cycle model of the line schedule.
module tb_conv5x5_feeder;

  localparam int C = 8;
  localparam int L = 11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, reuse_w, w_valid, w_ready, px_valid, px_ready;
  logic [19:0] w_data;
  logic [39:0] px_data;
  logic [7:0]  in1, in2, in3, in4, in5;
  logic [3:0]  ctrl;
  logic        res_valid, res_msb, line_done, underrun;

  int total = 0;
  int bad   = 0;

  conv5x5_feeder #(.COLS(C), .OUT_LAT(L), .RES_DLY(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .reuse_w(reuse_w),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .px_valid(px_valid), .px_ready(px_ready), .px_data(px_data),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4), .in5(in5),
    .ctrl(ctrl), .res_valid(res_valid), .res_msb(res_msb),
    .line_done(line_done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One line from a start pulse; stall = w_valid-low cycles before beat 2, gap = column
  // with px_valid low (-1 for none), poke = re-issue start in the line_done cycle.
  task automatic run_line(input logic reuse, input int stall, input int gap,
                          input logic [7:0] pix, input logic [3:0] wbase, input logic poke);
    int W, ds, le, beat_tb, npairs, t, tp, j, r;
    logic hs, frozen, chk_in, e_wr, e_pr, e_rv, e_rm, e_ld;
    logic [3:0] e_ctrl, code;
    logic [7:0] e_in1, e_in5;
    W  = reuse ? 0 : 9 + stall;
    ds = 2 + W;
    le = ds + 2 * C + L + 1;
    beat_tb = 0;
    npairs  = 0;
    reuse_w = reuse;
    px_data = {8'(pix + 8'd4), 8'(pix + 8'd3), 8'(pix + 8'd2), 8'(pix + 8'd1), pix};
    for (int k = 0; k <= le; k++) begin
      start    = (k == 0) || (poke && k == le);
      w_valid  = !(stall > 0 && k >= 5 && k < 5 + stall);
      code     = wbase | 4'(beat_tb + 1);
      w_data   = {5{code}};
      px_valid = !(gap >= 0 && k == ds - 1 + 2 * gap);
      hs = w_valid & w_ready;
      @(posedge clk);
      #1;
      if (hs) beat_tb++;
      begin
        int m;
        m = k + 1;
        e_ctrl = 4'b0100; e_in1 = 8'h00; e_in5 = 8'h00; chk_in = 1'b1;
        e_wr = 1'b0; e_pr = 1'b0; e_rv = 1'b0; e_rm = 1'b0; e_ld = (m == le);
        if (!reuse && m >= 2 && m <= 1 + W) begin
          t = m - 2;
          frozen = (stall > 0 && t >= 4 && t < 4 + stall);
          tp = (t >= 4 + stall) ? t - stall : t;
          if (frozen) chk_in = 1'b0;
          else begin
            e_ctrl = (tp == 8) ? 4'b0001 : 4'b0000;
            e_in1  = {4'b0, wbase | 4'(tp / 2 + 1)};
            e_in5  = e_in1;
          end
        end
        if (!reuse && m >= 1 && m <= W) begin
          t = m - 1;
          tp = (t >= 4 + stall) ? t - stall : t;
          e_wr = (stall > 0 && t >= 4 && t < 4 + stall) || (tp % 2 == 0);
        end
        if (m >= ds && m < ds + 2 * C) begin
          j = m - ds;
          e_ctrl = (j % 2 == 0) ? 4'b0010 : 4'b1100;
          e_in1  = (j / 2 == gap) ? 8'h00 : pix;
          e_in5  = (j / 2 == gap) ? 8'h00 : 8'(pix + 8'd4);
        end
        if (m + 1 >= ds && m + 1 < ds + 2 * C && (m + 1 - ds) % 2 == 0) e_pr = 1'b1;
        if (m >= ds + 2 * C && m <= le) begin
          j = m - ds - 2 * C;
          e_ctrl = (j % 2 == 0) ? 4'b0010 : 4'b1100;
        end
        r = m - ds - L;
        if (r >= 8 && r < 2 * C) begin
          e_rv = 1'b1;
          e_rm = (r % 2 == 1);
        end
        chk($sformatf("ctrl@%0d", m), 32'(ctrl), 32'(e_ctrl));
        if (chk_in) begin
          chk($sformatf("in1@%0d", m), 32'(in1), 32'(e_in1));
          chk($sformatf("in5@%0d", m), 32'(in5), 32'(e_in5));
        end
        chk($sformatf("w_ready@%0d", m), 32'(w_ready), 32'(e_wr));
        chk($sformatf("px_ready@%0d", m), 32'(px_ready), 32'(e_pr));
        chk($sformatf("res_valid@%0d", m), 32'(res_valid), 32'(e_rv));
        if (e_rv) chk($sformatf("res_msb@%0d", m), 32'(res_msb), 32'(e_rm));
        chk($sformatf("line_done@%0d", m), 32'(line_done), 32'(e_ld));
        if (m == 1) chk("underrun_clr", 32'(underrun), 32'd0);
        if (res_valid && !res_msb) npairs++;
      end
    end
    start = 1'b0;
    chk("pairs", 32'(npairs), 32'(C - 4));
    chk("underrun_end", 32'(underrun), (gap >= 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; reuse_w = 1'b0; w_valid = 1'b0; px_valid = 1'b0;
    w_data = '0; px_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", 32'(ctrl), 32'h4);
    chk("rst_in1", 32'(in1), 32'h0);
    chk("rst_w_ready", 32'(w_ready), 32'h0);
    chk("rst_px_ready", 32'(px_ready), 32'h0);
    chk("rst_flags", {28'h0, res_valid, res_msb, line_done, underrun}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Weight load codes 1..5, unit pixels, start poked during line_done
    run_line(1'b0, 0, -1, 8'h01, 4'h0, 1'b1);
    // Reused weights, one missing column mid-line
    run_line(1'b1, 0, 3, 8'h03, 4'h0, 1'b0);

    // Asynchronous reset while in DATA_M
    start = 1'b1; reuse_w = 1'b1; px_valid = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_ctrl", 32'(ctrl), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ctrl", 32'(ctrl), 32'h4);
    chk("arst_in1", 32'(in1), 32'h0);
    chk("arst_px_ready", 32'(px_ready), 32'h0);
    chk("arst_flags", {28'h0, res_valid, res_msb, line_done, underrun}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Clean reload with sign codes and a 3-cycle stall before beat 2
    run_line(1'b0, 3, -1, 8'h03, 4'h8, 1'b0);
    // Reused weights, first column missing, wrapping pixel rows
    run_line(1'b1, 0, 0, 8'hFE, 4'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv5x5_feeder.md
# conv5x5_feeder

Upstream sequencer for the 5x5 power-of-two systolic convolution kernel. It loads the 25 sign/shift weight codes into the PE chains and then streams 5-row pixel columns in the kernel's byte-serial LSB/MSB format. It generates the kernel's 4-bit `ctrl` word and tags the kernel's result byte stream for the downstream collector. The block replaces hand-written testbench sequencing; it has one instance per kernel5x5.

## Interface
- `COLS`, default 32: pixel columns per line; minimum 5.
- `OUT_LAT`, default 11: cycles from a column's LSB cycle on `in1..in5` to its LSB result byte on the kernel `out`.
- `RES_DLY`, default 0: delay of `ctrl[3]` relative to the MSB phase.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a line; ignored unless in IDLE.
- `reuse_w`  in  1  sampled with `start`; 1 skips the weight load.
- `w_valid`  in  1  weight beat valid.
- `w_ready`  out  1  weight beat accepted when `w_valid & w_ready`.
- `w_data`  in  20  one kernel column: `[4r+3:4r]` is the code for row r+1; bit3 is the sign, bits2:0 the shift.
- `px_valid`  in  1  pixel column valid.
- `px_ready`  out  1  pixel column accepted when `px_valid & px_ready`.
- `px_data`  in  40  pixel column: `[8r+7:8r]` is row r+1.
- `in1..in5`  out  8 each  kernel x/w inputs, registered.
- `ctrl`  out  4  kernel control, registered: bit0 StoreW, bit1 LSB, bit2 Circulate (freeze x), bit3 result-adder carry select.
- `res_valid`  out  1  the kernel `out` byte this cycle belongs to a full-window result.
- `res_msb`  out  1  with `res_valid`: 0 = LSB byte, 1 = MSB byte.
- `line_done`  out  1  one-cycle pulse at the end of DRAIN.
- `underrun`  out  1  sticky error flag; cleared only by reset or by `start`.

## Operation
- States: IDLE, WLOAD, DATA_L, DATA_M, DRAIN.
- **IDLE:** `ctrl`=4'b0100 (frozen), `in*`=0.
  - `start` with `reuse_w`=0 enters WLOAD.
  - `start` with `reuse_w`=1 enters DATA_L.
- **WLOAD:** takes 5 beats, kernel column 5 first and column 1 last.
  - Beats 0..3 each occupy 2 active cycles with `ctrl`=4'b0000.
  - Beat 4 occupies 1 active cycle with `ctrl`=4'b0001 (StoreW).
  - This places column c's code at PE c's input on the store cycle, because the per-PE x delay is 2 cycles.
  - `in{r}`={4'b0, code}.
  - `w_ready`=1 only on a beat's first cycle.
  - If `w_valid`=0 on that cycle, drive `ctrl`=4'b0100 and repeat the slot. Frozen cycles do not count as active.
  - After the store cycle, go to DATA_L.
- **DATA_L** (LSB cycle): `px_ready`=1, `ctrl[2:0]`=3'b010, `in{r}`=pixel row r.
  - If `px_valid`=0: drive zeros, set `underrun`, and still proceed. The array cannot be stalled mid-line.
  - Then go to DATA_M.
- **DATA_M:** `ctrl[2:0]`=3'b100 and `in*` unchanged.
  - Increment the column counter.
  - After column `COLS`-1, go to DRAIN; otherwise go to DATA_L.
- **DRAIN:** runs `OUT_LAT`+2 cycles, alternating the L/M `ctrl` pattern with zero pixels. Then pulse `line_done` and go to IDLE. Weights are retained.
- **`ctrl[3]`:** equals "current cycle is an MSB cycle" delayed by `RES_DLY` cycles. It is 0 outside DATA/DRAIN.
- **Result tags:** a column index c≥4 (0-based) completes a 5-wide window.
  - Its LSB cycle, delayed `OUT_LAT`, raises `res_valid` with `res_msb`=0.
  - The next cycle raises `res_valid` with `res_msb`=1.
  - Implement the tags with an `OUT_LAT`+1-deep tag shift register that keeps running through DRAIN.
- **Reset** (asynchronous, takes effect immediately):
  - state = IDLE; counters = 0; tag pipe = 0.
  - `ctrl`=4'b0100; `in*`=0.
  - `w_ready`=`px_ready`=`res_valid`=`res_msb`=`line_done`=`underrun`=0.
- Reset during any state abandons the line. Weights already in the PEs are not cleared, but a subsequent `reuse_w`=1 is only legal after a completed WLOAD since reset.

## Timing
- All outputs are registered. `w_ready`/`px_ready` are asserted in the cycle in which the beat is consumed.
- WLOAD is 9 active cycles minimum. DATA is 2·`COLS` cycles. DRAIN is `OUT_LAT`+2 cycles.
- Line latency, `start` to `line_done`:
  - with `reuse_w`=0 and no weight stalls: 1+9+2·`COLS`+`OUT_LAT`+2 cycles;
  - with `reuse_w`=1: 9 cycles fewer.
- A `start` arriving in the same cycle as `line_done` is ignored. It must be re-issued in IDLE.
- Pixel throughput is one column per 2 cycles, and there is no back-pressure on results.

## Test plan
- Weight load with `w_valid` held high and codes 0x1..0x5: `in1` sequence 1,1,2,2,3,3,4,4,5 with `ctrl`=0,0,0,0,0,0,0,0,1 → the PEs in row 1 store columns 1..5 = 5,4,3,2,1.
- Weight load with `w_valid` dropped for 3 cycles before beat 2 → 3 cycles of `ctrl`=4'b0100 inserted; stored codes identical to the unstalled case.
- `COLS`=8, all weights 4'b0000 (×1), pixels = 1 → 4 results, each res_valid pair LSB=25, MSB=0; `line_done` at cycle 1+9+16+13.
- Sign check: all weights 4'b1001 (−2), pixels = 3 → each result is −150: LSB byte 0x6A, MSB byte 0xFF.
- `px_valid` low for one column mid-line → `underrun`=1 sticky, zeros injected, and the line still completes with exactly `COLS`−4 result pairs.
- Assert `rst_n`=0 in the middle of DATA_M → outputs take their reset values immediately; a new `start` with `reuse_w`=0 runs a clean line.
